// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - shared class codes, RV32 opcodes, funct3 constants and queue entry type
package instr_encoder_pkg;

  typedef enum logic [3:0] {
    CLS_IMMOP = 4'd0,
    CLS_ROP   = 4'd1,
    CLS_LUI   = 4'd2,
    CLS_AUIPC = 4'd3,
    CLS_JAL   = 4'd4,
    CLS_JALR  = 4'd5,
    CLS_BOP   = 4'd6,
    CLS_SOP   = 4'd7,
    CLS_LOP   = 4'd8
  } cls_e;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL     = 3'b101;
  localparam logic [2:0] F3_BR_RSV0 = 3'b010;
  localparam logic [2:0] F3_BR_RSV1 = 3'b011;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_LD_RSV0 = 3'b011;
  localparam logic [2:0] F3_LD_RSV1 = 3'b110;
  localparam logic [2:0] F3_LD_RSV2 = 3'b111;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] addr;
    logic        err;
  } q_entry_t;

  // True when v, read as signed, fits in a two's-complement field of 'bits' bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic signed [31:0] s;
    s = $signed(v) >>> (bits - 1);
    return (s == 0) || (s == -1);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - request/word handshake bundle between a producer and the encoder
interface instr_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_class;
  logic [2:0]  req_funct3;
  logic        req_sub;
  logic        req_mext;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;
  logic        load_addr;
  logic [31:0] start_addr;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word;
  logic [31:0] word_addr;
  logic        word_err;
  logic [7:0]  err_count;

  modport master (
    output req_valid, req_class, req_funct3, req_sub, req_mext, req_rd, req_rs1, req_rs2,
           req_imm, load_addr, start_addr, word_ready,
    input  req_ready, word_valid, word, word_addr, word_err, err_count
  );

  modport slave (
    input  req_valid, req_class, req_funct3, req_sub, req_mext, req_rd, req_rs1, req_rs2,
           req_imm, load_addr, start_addr, word_ready,
    output req_ready, word_valid, word, word_addr, word_err, err_count
  );
endinterface

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational RV32IM field packing and legality check
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [3:0]  class_i,
  input  logic [2:0]  funct3_i,
  input  logic        sub_i,
  input  logic        mext_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        err_o
);

  logic [31:0] enc;
  logic        bad;
  logic        is_shift;

  assign is_shift = (funct3_i == F3_SLL) || (funct3_i == F3_SRL);

  always_comb begin
    enc = NOP_WORD;
    bad = 1'b0;
    case (class_i)
      CLS_IMMOP: begin
        if (is_shift) begin
          enc = {1'b0, sub_i & (funct3_i == F3_SRL), 5'b0, imm_i[4:0], rs1_i, funct3_i, rd_i, OPC_OPIMM};
          bad = |imm_i[31:5];
        end else begin
          enc = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_OPIMM};
          bad = !fits_signed(imm_i, 12);
        end
      end
      CLS_ROP: enc = {1'b0, sub_i, 4'b0, mext_i, rs2_i, rs1_i, funct3_i, rd_i, OPC_OP};
      CLS_LUI, CLS_AUIPC: begin
        enc = {imm_i[31:12], rd_i, (class_i == CLS_LUI) ? OPC_LUI : OPC_AUIPC};
        bad = |imm_i[11:0];
      end
      CLS_JAL: begin
        enc = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
        bad = imm_i[0] | !fits_signed(imm_i, 21);
      end
      CLS_JALR, CLS_LOP: begin
        enc = {imm_i[11:0], rs1_i, funct3_i, rd_i, (class_i == CLS_JALR) ? OPC_JALR : OPC_LOAD};
        bad = !fits_signed(imm_i, 12) |
              ((class_i == CLS_LOP) &&
               (funct3_i == F3_LD_RSV0 || funct3_i == F3_LD_RSV1 || funct3_i == F3_LD_RSV2));
      end
      CLS_BOP: begin
        enc = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], OPC_BRANCH};
        bad = imm_i[0] | !fits_signed(imm_i, 13) |
              (funct3_i == F3_BR_RSV0) | (funct3_i == F3_BR_RSV1);
      end
      CLS_SOP: begin
        enc = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OPC_STORE};
        bad = !fits_signed(imm_i, 12) | (funct3_i > F3_SW);
      end
      default: bad = 1'b1;
    endcase
    if (mext_i && (class_i != CLS_ROP)) bad = 1'b1;
  end

  assign word_o = bad ? NOP_WORD : enc;
  assign err_o  = bad;

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encoder top: address counter, error counter and output word queue
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input logic           clk,
  input logic           rst_n,
  instr_encoder_if.slave bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  q_entry_t       mem_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic [31:0]    addr_q, addr_d, slot_addr;
  logic [7:0]     err_cnt_q, err_cnt_d;
  logic           push, pop;
  logic [31:0]    pack_word;
  logic           pack_err;

  instr_pack u_pack (
    .class_i  (bus.req_class),
    .funct3_i (bus.req_funct3),
    .sub_i    (bus.req_sub),
    .mext_i   (bus.req_mext),
    .rd_i     (bus.req_rd),
    .rs1_i    (bus.req_rs1),
    .rs2_i    (bus.req_rs2),
    .imm_i    (bus.req_imm),
    .word_o   (pack_word),
    .err_o    (pack_err)
  );

  assign bus.req_ready  = (count_q != CW'(FIFO_DEPTH));
  assign bus.word_valid = (count_q != '0);
  assign bus.word       = mem_q[rd_ptr_q].word;
  assign bus.word_addr  = mem_q[rd_ptr_q].addr;
  assign bus.word_err   = mem_q[rd_ptr_q].err;
  assign bus.err_count  = err_cnt_q;

  assign push      = bus.req_valid && bus.req_ready;
  assign pop       = bus.word_valid && bus.word_ready;
  // A load coinciding with an accept hands start_addr straight to that request.
  assign slot_addr = bus.load_addr ? bus.start_addr : addr_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    addr_d = addr_q;
    if (push)               addr_d = slot_addr + 32'd4;
    else if (bus.load_addr) addr_d = bus.start_addr;
    err_cnt_d = err_cnt_q;
    if (push && pack_err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      addr_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {pack_word, slot_addr, pack_err};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q   <= count_d;
      addr_q    <= addr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_encoder_if bus ();

  instr_encoder #(.FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_addr = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic set_req(input logic [3:0] c, input logic [2:0] f3, input logic sb, input logic mx,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
    bus.req_class  = c;
    bus.req_funct3 = f3;
    bus.req_sub    = sb;
    bus.req_mext   = mx;
    bus.req_rd     = rd;
    bus.req_rs1    = rs1;
    bus.req_rs2    = rs2;
    bus.req_imm    = imm;
    bus.req_valid  = 1'b1;
  endtask

  task automatic send(input logic [3:0] c, input logic [2:0] f3, input logic sb, input logic mx,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm);
    int n = 0;
    @(negedge clk);
    set_req(c, f3, sb, mx, rd, rs1, rs2, imm);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] w, input logic e);
    int n = 0;
    while (!bus.word_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(bus.word_valid), 32'd1);
    check({tag, "_word"},  bus.word, w);
    check({tag, "_addr"},  bus.word_addr, exp_addr);
    check({tag, "_err"},   32'(bus.word_err), 32'(e));
    exp_addr = exp_addr + 32'd4;
    bus.word_ready = 1'b1;
    @(negedge clk);
    bus.word_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_class  = '0;
    bus.req_funct3 = '0;
    bus.req_sub    = 1'b0;
    bus.req_mext   = 1'b0;
    bus.req_rd     = '0;
    bus.req_rs1    = '0;
    bus.req_rs2    = '0;
    bus.req_imm    = '0;
    bus.load_addr  = 1'b0;
    bus.start_addr = '0;
    bus.word_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_word_valid", 32'(bus.word_valid), 32'd0);
    check("rst_word",       bus.word, 32'h0);
    check("rst_word_addr",  bus.word_addr, 32'h0);
    check("rst_word_err",   32'(bus.word_err), 32'd0);
    check("rst_err_count",  32'(bus.err_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(bus.req_ready), 32'd1);

    // Legal encodings
    send(4'd0, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    check("addi_latency", 32'(bus.word_valid), 32'd1);
    expect_word("addi", 32'h0050_0093, 1'b0);
    send(4'd1, 3'b000, 1'b1, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    expect_word("sub", 32'h4020_81B3, 1'b0);
    send(4'd6, 3'b000, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd4);
    expect_word("beq", 32'hFE20_8EE3, 1'b0);
    send(4'd4, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);
    expect_word("jal", 32'h0010_00EF, 1'b0);
    send(4'd6, 3'b000, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
    expect_word("beq_odd", NOP_WORD, 1'b1);
    check("err_count_1", 32'(bus.err_count), 32'd1);
    send(4'd2, 3'b000, 1'b0, 1'b0, 5'd5, 5'd7, 5'd7, 32'h1234_5000);
    expect_word("lui", 32'h1234_52B7, 1'b0);
    send(4'd1, 3'b000, 1'b0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
    expect_word("mul", 32'h0220_81B3, 1'b0);
    send(4'd0, 3'b101, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 32'd3);
    expect_word("srai", 32'h4031_5093, 1'b0);
    send(4'd7, 3'b010, 1'b0, 1'b0, 5'd9, 5'd2, 5'd3, 32'd8);
    expect_word("sw", 32'h0031_2423, 1'b0);
    send(4'd0, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2047);
    expect_word("addi_max", 32'h7FF0_0093, 1'b0);
    send(4'd0, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, -32'sd2048);
    expect_word("addi_min", 32'h8000_0093, 1'b0);
    send(4'd4, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFF0_0000);
    expect_word("jal_min", 32'h8000_006F, 1'b0);

    // Illegal requests
    send(4'd0, 3'b001, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd32);
    expect_word("slli_32", NOP_WORD, 1'b1);
    send(4'd0, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);
    expect_word("addi_2048", NOP_WORD, 1'b1);
    send(4'd4, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0010_0000);
    expect_word("jal_big", NOP_WORD, 1'b1);
    send(4'd0, 3'b000, 1'b0, 1'b1, 5'd1, 5'd0, 5'd0, 32'd1);
    expect_word("mext_imm", NOP_WORD, 1'b1);
    send(4'd9, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0);
    expect_word("class_9", NOP_WORD, 1'b1);
    send(4'd6, 3'b010, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd0);
    expect_word("bop_f3", NOP_WORD, 1'b1);
    send(4'd7, 3'b011, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd0);
    expect_word("sop_f3", NOP_WORD, 1'b1);
    send(4'd2, 3'b000, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5001);
    expect_word("lui_low", NOP_WORD, 1'b1);
    send(4'd8, 3'b011, 1'b0, 1'b0, 5'd5, 5'd1, 5'd0, 32'd0);
    expect_word("lop_f3", NOP_WORD, 1'b1);
    check("err_count_10", 32'(bus.err_count), 32'd10);

    // Saturation
    bus.word_ready = 1'b1;
    for (int i = 0; i < 256; i++) send(4'hF, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    @(negedge clk);
    bus.word_ready = 1'b0;
    check("err_count_sat", 32'(bus.err_count), 32'd255);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst2_err_count", 32'(bus.err_count), 32'd0);
    exp_addr = 32'h0;

    // Backpressure with depth 2
    @(negedge clk);
    set_req(4'd0, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
    @(negedge clk);
    check("bp_ready1", 32'(bus.req_ready), 32'd1);
    bus.req_imm = 32'd2;
    @(negedge clk);
    check("bp_ready2", 32'(bus.req_ready), 32'd0);
    bus.req_imm = 32'd3;
    repeat (2) @(negedge clk);
    check("bp_hold_ready", 32'(bus.req_ready), 32'd0);
    check("bp_hold_word",  bus.word, 32'h0010_0093);
    check("bp_hold_addr",  bus.word_addr, 32'h0);
    bus.word_ready = 1'b1;
    @(negedge clk);
    check("bp_w2_word", bus.word, 32'h0020_0093);
    check("bp_w2_addr", bus.word_addr, 32'h4);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("bp_w3_word", bus.word, 32'h0030_0093);
    check("bp_w3_addr", bus.word_addr, 32'h8);
    check("bp_w3_err",  32'(bus.word_err), 32'd0);
    @(negedge clk);
    bus.word_ready = 1'b0;
    check("bp_empty", 32'(bus.word_valid), 32'd0);
    exp_addr = 32'hC;

    // Address loading, with and without a coinciding accept, and wrap
    @(negedge clk);
    set_req(4'd0, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd7);
    bus.load_addr  = 1'b1;
    bus.start_addr = 32'h100;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.load_addr = 1'b0;
    exp_addr = 32'h100;
    expect_word("load_acc", 32'h0070_0093, 1'b0);
    send(4'd0, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
    expect_word("load_next", 32'h0080_0093, 1'b0);
    @(negedge clk);
    bus.load_addr  = 1'b1;
    bus.start_addr = 32'h200;
    @(negedge clk);
    bus.load_addr = 1'b0;
    exp_addr = 32'h200;
    send(4'd0, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd9);
    expect_word("load_idle", 32'h0090_0093, 1'b0);
    @(negedge clk);
    bus.load_addr  = 1'b1;
    bus.start_addr = 32'hFFFF_FFFC;
    @(negedge clk);
    bus.load_addr = 1'b0;
    exp_addr = 32'hFFFF_FFFC;
    send(4'd0, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd10);
    expect_word("wrap_top", 32'h00A0_0093, 1'b0);
    send(4'd0, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd11);
    expect_word("wrap_zero", 32'h00B0_0093, 1'b0);

    // Reset with two words queued
    send(4'd0, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
    send(4'd0, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2);
    check("mid_full", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.word_valid), 32'd0);
    check("mid_rst_addr",  bus.word_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_post_valid", 32'(bus.word_valid), 32'd0);
    exp_addr = 32'h0;
    send(4'd0, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    expect_word("after_rst", 32'h0050_0093, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
